// File: rtl/toy_mem_responder_if.sv
// Bundled memory-side handshake signals between the core (master) and toy_mem_responder (slave).
// Signals keep the responder-relative _i/_o names so both ends read the same as the port list.
`ifndef MEM_RPORTS
`define MEM_RPORTS 3
`endif

interface toy_mem_responder_if #(
    parameter int NR = `MEM_RPORTS,
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [NR-1:0]    r_val_i;
    logic [NR*AW-1:0] r_addr_i;
    logic [NR-1:0]    r_rdy_o;
    logic [NR*DW-1:0] r_rdata_o;

    logic             rw_val_i;
    logic             rw_wen_i;
    logic [AW-1:0]    rw_addr_i;
    logic [DW-1:0]    rw_wdata_i;
    logic             rw_rdy_o;
    logic [DW-1:0]    rw_rdata_o;

    logic             pnl_val_i;
    logic             pnl_wen_i;
    logic [AW-1:0]    pnl_addr_i;
    logic [DW-1:0]    pnl_wdata_i;
    logic             pnl_rdy_o;
    logic [DW-1:0]    pnl_rdata_o;

    modport master (
        output r_val_i, r_addr_i,
        output rw_val_i, rw_wen_i, rw_addr_i, rw_wdata_i,
        output pnl_val_i, pnl_wen_i, pnl_addr_i, pnl_wdata_i,
        input  r_rdy_o, r_rdata_o, rw_rdy_o, rw_rdata_o, pnl_rdy_o, pnl_rdata_o
    );

    modport slave (
        input  r_val_i, r_addr_i,
        input  rw_val_i, rw_wen_i, rw_addr_i, rw_wdata_i,
        input  pnl_val_i, pnl_wen_i, pnl_addr_i, pnl_wdata_i,
        output r_rdy_o, r_rdata_o, rw_rdy_o, rw_rdata_o, pnl_rdy_o, pnl_rdata_o
    );
endinterface

// File: rtl/toy_mem_responder.sv
// TOY main memory responder: round-robin fetch ports, dedicated load/store port, panel port, clear sweep.
// Optional build macro MEM_RESP_COLLIDE_STALL_EN stalls reads that hit the address being stored this cycle.
//
// state    | meaning
// ST_INIT  | clearing sweep, one location per cycle, no grants, busy_o = 1
// ST_READY | serving fetch, load/store and panel requests
`ifndef MEM_RPORTS
`define MEM_RPORTS 3
`endif

module toy_mem_responder #(
    parameter int NR    = `MEM_RPORTS,
    parameter int NPHYS = 2,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               clr_i,
    output logic               busy_o,
    toy_mem_responder_if.slave bus
);
    localparam int PW    = (NR > 1) ? $clog2(NR) : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_READY
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    w_rr_nxt;
    logic [DW-1:0]    r_mem [DEPTH];

    logic             w_ready;
    logic             w_rw_store;
    logic             w_rw_rdy;
    logic             w_pnl_rdy;
    logic [NR-1:0]    w_r_coll;
    logic [NR-1:0]    w_r_gnt;
    logic [NR*DW-1:0] w_r_rdata;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [DW-1:0]    w_wdata;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_ready    = (r_state == ST_READY);
    assign busy_o     = ~w_ready;
    assign w_rw_store = bus.rw_val_i && bus.rw_wen_i;

`ifdef MEM_RESP_COLLIDE_STALL_EN
    always_comb begin
        w_r_coll = '0;
        for (int k = 0; k < NR; k++) begin
            w_r_coll[k] = w_rw_store && (bus.r_addr_i[k*AW +: AW] == bus.rw_addr_i);
        end
    end
`else
    assign w_r_coll = '0;
`endif

    // Scan from r_rr_ptr; the first valid port left without a grant becomes the next start point.
    always_comb begin
        int   idx;
        int   n_gnt;
        logic found;
        w_r_gnt  = '0;
        w_rr_nxt = r_rr_ptr;
        idx      = 0;
        n_gnt    = 0;
        found    = 1'b0;
        if (w_ready) begin
            for (int i = 0; i < NR; i++) begin
                idx = int'(r_rr_ptr) + i;
                if (idx >= NR) begin
                    idx = idx - NR;
                end
                if (bus.r_val_i[idx]) begin
                    if (!w_r_coll[idx] && (n_gnt < NPHYS)) begin
                        w_r_gnt[idx] = 1'b1;
                        n_gnt        = n_gnt + 1;
                    end else if (!found) begin
                        found    = 1'b1;
                        w_rr_nxt = PW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        w_r_rdata = '0;
        for (int k = 0; k < NR; k++) begin
            if (w_r_gnt[k]) begin
                w_r_rdata[k*DW +: DW] = r_mem[bus.r_addr_i[k*AW +: AW]];
            end
        end
    end

    // Panel yields on any rw request, so it can never collide with a store.
    assign w_rw_rdy  = w_ready && bus.rw_val_i;
    assign w_pnl_rdy = w_ready && bus.pnl_val_i && !bus.rw_val_i;

    assign bus.r_rdy_o     = w_r_gnt;
    assign bus.r_rdata_o   = w_r_rdata;
    assign bus.rw_rdy_o    = w_rw_rdy;
    assign bus.rw_rdata_o  = w_rw_rdy ? r_mem[bus.rw_addr_i] : '0;
    assign bus.pnl_rdy_o   = w_pnl_rdy;
    assign bus.pnl_rdata_o = w_pnl_rdy ? r_mem[bus.pnl_addr_i] : '0;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = '0;
        if (!w_ready) begin
            w_we = 1'b1;
        end else if (w_rw_store) begin
            w_we    = 1'b1;
            w_waddr = bus.rw_addr_i;
            w_wdata = bus.rw_wdata_i;
        end else if (w_pnl_rdy && bus.pnl_wen_i) begin
            w_we    = 1'b1;
            w_waddr = bus.pnl_addr_i;
            w_wdata = bus.pnl_wdata_i;
        end
    end

    // Array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end
endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench for toy_mem_responder with NR = 3, NPHYS = 2; inputs change on negedge, outputs sampled 1 unit later.
// Collision expectations follow whether MEM_RESP_COLLIDE_STALL_EN is defined for the build.
module tb_toy_mem_responder;
    localparam int NR    = 3;
    localparam int NPHYS = 2;
    localparam int AW    = 8;
    localparam int DW    = 16;

    logic clk_i   = 1'b0;
    logic arst_ni = 1'b0;
    logic clr_i   = 1'b0;
    logic busy_o;

    int n_checks = 0;
    int n_errs   = 0;
    int bad      = 0;

    toy_mem_responder_if #(.NR(NR), .AW(AW), .DW(DW)) bus ();

    toy_mem_responder #(.NR(NR), .NPHYS(NPHYS), .AW(AW), .DW(DW)) dut (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .clr_i  (clr_i),
        .busy_o (busy_o),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.r_val_i     = '0;
        bus.r_addr_i    = '0;
        bus.rw_val_i    = 1'b0;
        bus.rw_wen_i    = 1'b0;
        bus.rw_addr_i   = '0;
        bus.rw_wdata_i  = '0;
        bus.pnl_val_i   = 1'b0;
        bus.pnl_wen_i   = 1'b0;
        bus.pnl_addr_i  = '0;
        bus.pnl_wdata_i = '0;
        clr_i           = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    // Counts posedges until busy_o drops; any grant seen while busy is tallied in bad_cnt.
    task automatic wait_ready(input string tag, input int exp_n, output int bad_cnt);
        int n;
        n       = 0;
        bad_cnt = 0;
        while (busy_o && n < 600) begin
            tick();
            n++;
            if (busy_o && ((bus.r_rdy_o != '0) || bus.rw_rdy_o || bus.pnl_rdy_o)) begin
                bad_cnt++;
            end
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic rw_op(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.rw_val_i   = 1'b1;
        bus.rw_wen_i   = wen;
        bus.rw_addr_i  = addr;
        bus.rw_wdata_i = wdata;
    endtask

    initial begin
        idle();
        // Reset asserted with every requester active.
        bus.r_val_i   = 3'b111;
        bus.r_addr_i  = {8'h02, 8'h01, 8'h00};
        bus.rw_val_i  = 1'b1;
        bus.pnl_val_i = 1'b1;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd1);
        chk("rst_r_rdy", 64'(bus.r_rdy_o), 64'd0);
        chk("rst_r_rdata", 64'(bus.r_rdata_o), 64'd0);
        chk("rst_rw_rdy", 64'(bus.rw_rdy_o), 64'd0);
        chk("rst_rw_rdata", 64'(bus.rw_rdata_o), 64'd0);
        chk("rst_pnl_rdy", 64'(bus.pnl_rdy_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
        #1;
        wait_ready("init_cycles", 256, bad);
        chk("init_no_grants", 64'(bad), 64'd0);
        idle();

        // Cleared memory reads back zero through every port.
        rw_op(1'b0, 8'h00, 16'h0);
        #1;
        chk("clr_rw_rdy", 64'(bus.rw_rdy_o), 64'd1);
        chk("clr_rw_00", 64'(bus.rw_rdata_o), 64'd0);
        tick();
        idle();
        bus.r_val_i  = 3'b100;
        bus.r_addr_i = {8'hFF, 8'h00, 8'h00};
        #1;
        chk("clr_fetch_rdy", 64'(bus.r_rdy_o), 64'b100);
        chk("clr_fetch_ff", 64'(bus.r_rdata_o), 64'd0);
        tick();
        idle();
        bus.pnl_val_i  = 1'b1;
        bus.pnl_addr_i = 8'h7F;
        #1;
        chk("clr_pnl_rdy", 64'(bus.pnl_rdy_o), 64'd1);
        chk("clr_pnl_7f", 64'(bus.pnl_rdata_o), 64'd0);
        tick();
        idle();

        // Store then fetch.
        rw_op(1'b1, 8'h10, 16'h1234);
        #1;
        chk("st_rw_rdy", 64'(bus.rw_rdy_o), 64'd1);
        chk("st_old_data", 64'(bus.rw_rdata_o), 64'd0);
        tick();
        idle();
        bus.r_val_i  = 3'b001;
        bus.r_addr_i = {8'h00, 8'h00, 8'h10};
        #1;
        chk("fetch_rdy", 64'(bus.r_rdy_o), 64'b001);
        chk("fetch_data", 64'(bus.r_rdata_o), 64'h0000_0000_1234);
        chk("rw_idle_rdata", 64'(bus.rw_rdata_o), 64'd0);
        tick();

        // Round-robin with all three ports fetching 0x10.
        bus.r_val_i  = 3'b111;
        bus.r_addr_i = {8'h10, 8'h10, 8'h10};
        #1;
        chk("rr0_gnt", 64'(bus.r_rdy_o), 64'b011);
        chk("rr0_data", 64'(bus.r_rdata_o), 64'h0000_1234_1234);
        tick();
        chk("rr1_gnt", 64'(bus.r_rdy_o), 64'b101);
        chk("rr1_data", 64'(bus.r_rdata_o), 64'h1234_0000_1234);
        tick();
        chk("rr2_gnt", 64'(bus.r_rdy_o), 64'b110);
        chk("rr2_data", 64'(bus.r_rdata_o), 64'h1234_1234_0000);
        tick();
        idle();

        // Panel yields to a concurrent load.
        bus.pnl_val_i   = 1'b1;
        bus.pnl_wen_i   = 1'b1;
        bus.pnl_addr_i  = 8'h20;
        bus.pnl_wdata_i = 16'hBEEF;
        rw_op(1'b0, 8'h30, 16'h0);
        #1;
        chk("pnl_yield_rdy", 64'(bus.pnl_rdy_o), 64'd0);
        chk("pnl_yield_rw", 64'(bus.rw_rdy_o), 64'd1);
        tick();
        bus.rw_val_i = 1'b0;
        #1;
        chk("pnl_wr_rdy", 64'(bus.pnl_rdy_o), 64'd1);
        tick();
        bus.pnl_wen_i = 1'b0;
        #1;
        chk("pnl_rd_rdy", 64'(bus.pnl_rdy_o), 64'd1);
        chk("pnl_rd_data", 64'(bus.pnl_rdata_o), 64'hBEEF);
        tick();
        idle();
        rw_op(1'b0, 8'h20, 16'h0);
        #1;
        chk("rw_rd_beef", 64'(bus.rw_rdata_o), 64'hBEEF);
        tick();
        idle();

        // Store/fetch collision on 0x40.
        rw_op(1'b1, 8'h40, 16'h5555);
        tick();
        rw_op(1'b1, 8'h40, 16'hAAAA);
        bus.r_val_i  = 3'b010;
        bus.r_addr_i = {8'h00, 8'h40, 8'h00};
        #1;
        chk("coll_rw_old", 64'(bus.rw_rdata_o), 64'h5555);
`ifdef MEM_RESP_COLLIDE_STALL_EN
        chk("coll_stall_rdy", 64'(bus.r_rdy_o), 64'b000);
        chk("coll_stall_data", 64'(bus.r_rdata_o), 64'd0);
`else
        chk("coll_rdy", 64'(bus.r_rdy_o), 64'b010);
        chk("coll_old_data", 64'(bus.r_rdata_o), 64'h0000_5555_0000);
`endif
        tick();
        bus.rw_val_i = 1'b0;
        bus.rw_wen_i = 1'b0;
        #1;
        chk("coll_next_rdy", 64'(bus.r_rdy_o), 64'b010);
        chk("coll_next_data", 64'(bus.r_rdata_o), 64'h0000_AAAA_0000);
        tick();
        idle();

        // Top address behaves like any other.
        rw_op(1'b1, 8'hFF, 16'hCAFE);
        tick();
        idle();
        bus.r_val_i  = 3'b100;
        bus.r_addr_i = {8'hFF, 8'h00, 8'h00};
        #1;
        chk("ff_fetch", 64'(bus.r_rdata_o), 64'hCAFE_0000_0000);
        tick();
        idle();

        // Clear request with a concurrent store, plus an ignored clr mid-sweep.
        clr_i = 1'b1;
        rw_op(1'b1, 8'h50, 16'h7777);
        #1;
        chk("clr_cycle_rw_rdy", 64'(bus.rw_rdy_o), 64'd1);
        chk("clr_cycle_busy", 64'(busy_o), 64'd0);
        tick();
        idle();
        chk("clr_busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 49; i++) begin
            clr_i = (i == 20);
            tick();
        end
        clr_i = 1'b0;
        wait_ready("clr_sweep_len", 207, bad);
        chk("clr_no_grants", 64'(bad), 64'd0);
        rw_op(1'b0, 8'h10, 16'h0);
        #1;
        chk("clr_10", 64'(bus.rw_rdata_o), 64'd0);
        tick();
        rw_op(1'b0, 8'h50, 16'h0);
        #1;
        chk("clr_50", 64'(bus.rw_rdata_o), 64'd0);
        tick();
        idle();
        bus.r_val_i  = 3'b110;
        bus.r_addr_i = {8'hFF, 8'h40, 8'h00};
        #1;
        chk("clr_fetch_40_ff", 64'(bus.r_rdata_o), 64'd0);
        tick();
        idle();
        bus.pnl_val_i  = 1'b1;
        bus.pnl_addr_i = 8'h20;
        #1;
        chk("clr_pnl_20", 64'(bus.pnl_rdata_o), 64'd0);
        tick();
        idle();

        // Reset at cnt = 100 restarts the sweep.
        rw_op(1'b1, 8'h05, 16'h9999);
        tick();
        idle();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        arst_ni = 1'b1;
        #1;
        wait_ready("mid_rst_sweep", 256, bad);
        rw_op(1'b0, 8'h05, 16'h0);
        #1;
        chk("mid_rst_05", 64'(bus.rw_rdata_o), 64'd0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/toy_mem_responder.md
Name: toy_mem_responder

Overview:
- Responder end of the core's memory interfaces. Serves the core's `MEM_RPORTS instruction-fetch read ports (mem_rport) and its single load/store read-write port (mem_rwport).
- Holds the 256x16 TOY main memory.
- Arbitrates fetch reads onto a limited number of physical read ports.
- Offers a lowest-priority front-panel access port.
- Runs a clearing sweep after reset or on request.

Parameters:
- NR, `MEM_RPORTS: number of logical fetch read ports.
- NPHYS, 2: physical read ports per cycle (1..NR).
- AW, 8: address width; depth = 2**AW.
- DW, 16: data width.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous active-low reset
- r_val_i  in  NR  fetch request valid, per port
- r_addr_i  in  NR*AW  fetch address, port k at [k*AW +: AW]
- r_rdy_o  out  NR  fetch grant, per port
- r_rdata_o  out  NR*DW  fetch data, port k at [k*DW +: DW]
- rw_val_i  in  1  load/store request valid
- rw_wen_i  in  1  1 = store
- rw_addr_i  in  AW  load/store address
- rw_wdata_i  in  DW  store data
- rw_rdy_o  out  1  load/store grant
- rw_rdata_o  out  DW  load data
- pnl_val_i  in  1  panel request valid
- pnl_wen_i  in  1  panel write
- pnl_addr_i  in  AW  panel address
- pnl_wdata_i  in  DW  panel write data
- pnl_rdy_o  out  1  panel grant
- pnl_rdata_o  out  DW  panel read data
- clr_i  in  1  request clear sweep (pulse)
- busy_o  out  1  clear sweep in progress

Behaviour:
- Clock clk_i; reset arst_ni, asynchronous, active-low.
- On reset:
  - state = INIT, sweep counter = 0, rr_ptr = 0.
  - busy_o = 1.
  - All rdy outputs = 0; all rdata outputs = 0.
  - The memory array itself has no reset; the INIT sweep clears it.
- Handshake:
  - A transfer happens in a cycle where val && rdy.
  - rdy is combinational from val and the current state; no wait cycles once granted.
  - Read data is combinational (asynchronous array read) and valid in the handshake cycle.
  - A store commits at the next posedge. Same-cycle reads of that address return the old value.
  - rdata is 0 whenever rdy is 0.
- FSM:
  - INIT:
    - Each cycle writes 0 to mem[cnt], then cnt++.
    - All rdy = 0; busy_o = 1.
    - When cnt == 2**AW-1 is written, next state is READY. A sweep takes exactly 256 cycles.
  - READY:
    - busy_o = 0.
    - clr_i = 1 -> next state INIT with cnt = 0. Handshakes in that same cycle still complete.
  - clr_i during INIT is ignored.
- Fetch arbitration (READY):
  - Scan ports cyclically starting at rr_ptr. Grant the first NPHYS ports with r_val_i = 1.
  - Ports not asserting valid never get rdy.
  - rr_ptr update: if any valid port was denied, rr_ptr <= index of the first denied port in scan order; otherwise unchanged.
  - Worst-case wait is ceil(NR/NPHYS)-1 cycles.
- rw port (READY):
  - Dedicated access, always granted: rw_rdy_o = rw_val_i.
  - Load data = mem[rw_addr_i]; a load returns the old value.
- Panel port (READY):
  - pnl_rdy_o = pnl_val_i && ~rw_val_i. The panel yields to the core on any rw request, read or write.
  - Panel write commits at posedge.
- Addresses wrap modulo 2**AW. Address 0xFF is stored like any other address; stdio decode belongs to the core LSU.
- Reset mid-sweep restarts the sweep from cnt = 0.

Optional Feature:
- Macro: MEM_RESP_COLLIDE_STALL_EN.
- Defined:
  - Any fetch or panel read whose address equals rw_addr_i while rw_val_i && rw_wen_i gets rdy = 0 that cycle, and is retried next cycle.
  - A denied colliding fetch port counts as denied for the rr_ptr update.
  - Prevents stale-instruction fetch of freshly stored code.
- Undefined: colliding reads are granted and return the old value.

Test Plan:
- Reset release:
  - busy_o = 1 and all rdy = 0 for cycles 0..255 after deassert; READY at cycle 256.
  - Read of any address returns 0x0000.
- Store then fetch:
  - rw store 0x1234 to 0x10, next cycle r_addr 0x10 with r_val on port 0.
  - Required: r_rdy_o[0] = 1 and r_rdata_o = 0x1234 in the same cycle.
- Arbitration fairness (NR = 3, NPHYS = 2), all three ports requesting continuously:
  - Grants: cycle 0 ports 0,1; cycle 1 ports 2,0; cycle 2 ports 1,2.
  - No port waits more than 1 cycle.
- Panel yields:
  - pnl write 0xBEEF to 0x20 concurrent with a rw load of 0x30: pnl_rdy_o = 0.
  - Next cycle with rw idle: pnl_rdy_o = 1; a subsequent read of 0x20 returns 0xBEEF.
- Collision:
  - Store 0xAAAA to 0x40 with a same-cycle fetch of 0x40, prior content 0x5555.
  - Without macro: granted, returns 0x5555.
  - With macro: rdy = 0, next cycle returns 0xAAAA.
- Clear mid-run:
  - clr_i pulse in READY -> busy_o = 1 for 256 cycles, then all locations read 0.
  - arst_ni low at cnt = 100 restarts the sweep at cnt = 0.
